// File: rtl/bus_arbiter16.sv
// Two-requester bus arbiter with a registered shared data path.
// Ownership alternates on contention. A burst limit forces the bus over to a
// waiting requester. An owner with nobody waiting keeps the bus indefinitely.
module bus_arbiter16 #(
   parameter int MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_a,
   input  logic [0:15] data_a,
   input  logic        req_b,
   input  logic [0:15] data_b,
   output logic        grant_a,
   output logic        grant_b,
   output logic        sel,
   output logic [0:15] out,
   output logic        out_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

   state_t     state;
   state_t     next_state;
   logic       last_owner;
   logic [3:0] burst_cnt;
   logic [3:0] burst_inc;
   logic       owner_req;
   logic       other_req;
   logic       xfer;
   logic       entering;

   // Next-state selection, transfer detection and saturating burst count.
   // last_owner = 1 means B held the bus most recently, so A wins the next tie.
   always_comb begin
      owner_req  = 1'b0;
      other_req  = 1'b0;
      next_state = state;
      case (state)
         OWN_A: begin
            owner_req = req_a;
            other_req = req_b;
         end
         OWN_B: begin
            owner_req = req_b;
            other_req = req_a;
         end
         default: begin
            owner_req = 1'b0;
            other_req = 1'b0;
         end
      endcase
      xfer      = owner_req;
      burst_inc = (burst_cnt >= BURST_LIMIT) ? burst_cnt : burst_cnt + 4'd1;
      case (state)
         IDLE: begin
            if (req_a && req_b) begin
               next_state = last_owner ? OWN_A : OWN_B;
            end else if (req_a) begin
               next_state = OWN_A;
            end else if (req_b) begin
               next_state = OWN_B;
            end else begin
               next_state = IDLE;
            end
         end
         OWN_A: begin
            if (!req_a) begin
               next_state = req_b ? OWN_B : IDLE;
            end else if (req_b && (burst_inc == BURST_LIMIT)) begin
               next_state = OWN_B;
            end else begin
               next_state = OWN_A;
            end
         end
         OWN_B: begin
            if (!req_b) begin
               next_state = req_a ? OWN_A : IDLE;
            end else if (req_a && (burst_inc == BURST_LIMIT)) begin
               next_state = OWN_A;
            end else begin
               next_state = OWN_B;
            end
         end
         default: next_state = IDLE;
      endcase
      entering = (next_state != state) && (next_state != IDLE);
   end

   // State register; last_owner remembers who entered ownership most recently.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_owner <= 1'b1;
      end else begin
         state <= next_state;
         if (entering) begin
            last_owner <= (next_state == OWN_B);
         end
      end
   end

   // Burst counter restarts on each new ownership and counts transfers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         burst_cnt <= 4'd0;
      end else if (entering) begin
         burst_cnt <= 4'd0;
      end else if (xfer) begin
         burst_cnt <= burst_inc;
      end
   end

   // Shared data register; holds its value on cycles without a transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out       <= 16'h0000;
         out_valid <= 1'b0;
      end else begin
         out_valid <= xfer;
         if (xfer) begin
            out <= (state == OWN_B) ? data_b : data_a;
         end
      end
   end

   assign grant_a = (state == OWN_A);
   assign grant_b = (state == OWN_B);
   assign sel     = (state == OWN_B);

endmodule

// File: tb/tb_bus_arbiter16.sv
// Bench for bus_arbiter16: directed scenarios plus random traffic.
// A behavioural ownership model predicts the grants. Expected bus words are
// queued and then popped by an independent monitor whenever out_valid is seen.
module tb_bus_arbiter16;

   localparam int MAX_BURST = 4;

   logic        clk;
   logic        reset_n;
   logic        req_a;
   logic [0:15] data_a;
   logic        req_b;
   logic [0:15] data_b;
   logic        grant_a;
   logic        grant_b;
   logic        sel;
   logic [0:15] out;
   logic        out_valid;

   int checks   = 0;
   int failures = 0;

   // Model state: owner 0 = nobody, 1 = A, 2 = B; last is the most recent owner.
   int          mdl_owner;
   int          mdl_last;
   int          mdl_run;
   bit          mdl_valid;
   logic [15:0] mdl_out;
   logic [15:0] exp_q[$];

   bus_arbiter16 #(.MAX_BURST(MAX_BURST)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_a     (req_a),
      .data_a    (data_a),
      .req_b     (req_b),
      .data_b    (data_b),
      .grant_a   (grant_a),
      .grant_b   (grant_b),
      .sel       (sel),
      .out       (out),
      .out_valid (out_valid)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Compares every output against the model's view of the current cycle.
   task automatic checkOutput();
      check("grant_a", {15'd0, grant_a}, {15'd0, mdl_owner == 1});
      check("grant_b", {15'd0, grant_b}, {15'd0, mdl_owner == 2});
      check("sel", {15'd0, sel}, {15'd0, mdl_owner == 2});
      check("out_valid", {15'd0, out_valid}, {15'd0, mdl_valid});
      check("out", out, mdl_out);
   endtask

   task automatic modelReset();
      mdl_owner = 0;
      mdl_last  = 2;
      mdl_run   = 0;
      mdl_valid = 1'b0;
      mdl_out   = 16'h0000;
      exp_q.delete();
   endtask

   // Drives one cycle of inputs at the falling edge and predicts the next edge.
   task automatic applyStimulus(input bit ra, input bit rb, input logic [15:0] da,
                                input logic [15:0] db);
      bit mine;
      bit other;
      int nxt;
      @(negedge clk);
      req_a  = ra;
      req_b  = rb;
      data_a = da;
      data_b = db;
      mine   = (mdl_owner == 1) ? ra : (mdl_owner == 2) ? rb : 1'b0;
      other  = (mdl_owner == 1) ? rb : (mdl_owner == 2) ? ra : 1'b0;
      if (mdl_owner == 0) begin
         if (ra && rb)  nxt = (mdl_last == 1) ? 2 : 1;
         else if (ra)   nxt = 1;
         else if (rb)   nxt = 2;
         else           nxt = 0;
      end else if (!mine) begin
         nxt = other ? 3 - mdl_owner : 0;
      end else if (other && (mdl_run + 1 >= MAX_BURST)) begin
         nxt = 3 - mdl_owner;
      end else begin
         nxt = mdl_owner;
      end
      if (mine) exp_q.push_back((mdl_owner == 1) ? da : db);
      @(posedge clk);
      #1;
      if (mine) begin
         mdl_out = (mdl_owner == 1) ? da : db;
         mdl_run = (mdl_run + 1 > MAX_BURST) ? MAX_BURST : mdl_run + 1;
      end
      mdl_valid = mine;
      if (nxt != mdl_owner && nxt != 0) begin
         mdl_run  = 0;
         mdl_last = nxt;
      end
      mdl_owner = nxt;
      checkOutput();
   endtask

   // Asserts reset between clock edges; outputs must clear before any edge.
   task automatic resetDut();
      #2;
      reset_n = 1'b0;
      #1;
      modelReset();
      checkOutput();
      @(posedge clk);
      #1;
      checkOutput();
      @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   // Monitor: every presented bus word must match the oldest queued prediction.
   always @(negedge clk) begin
      logic [15:0] exp;
      if (reset_n === 1'b1 && out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL monitor_unexpected actual=%h required=none", out);
         end else begin
            exp = exp_q.pop_front();
            check("monitor_data", out, exp);
         end
      end
   end

   // Directed scenarios followed by random traffic.
   initial begin
      reset_n = 1'b0;
      req_a   = 1'b0;
      req_b   = 1'b0;
      data_a  = 16'h0000;
      data_b  = 16'h0000;
      modelReset();
      #1;
      checkOutput();
      @(posedge clk);
      @(posedge clk);
      #2;
      reset_n = 1'b1;

      // Idle after reset.
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 16'hDEAD, 16'hBEEF);

      // Single requester A.
      applyStimulus(1'b1, 1'b0, 16'h1234, 16'hFFFF);
      check("single_grant_a", {15'd0, grant_a}, 16'd1);
      applyStimulus(1'b1, 1'b0, 16'h1234, 16'hFFFF);
      check("single_out", out, 16'h1234);
      check("single_valid", {15'd0, out_valid}, 16'd1);
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 16'h1234, 16'hFFFF);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);

      // Contention: bursts of MAX_BURST alternate without gaps.
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b1, 1'b1, 16'(16'hA000 + i), 16'(16'hB000 + i));
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);

      // Owner drops its request while the other waits.
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 16'h0A0A, 16'h0B0B);
      applyStimulus(1'b0, 1'b1, 16'h0A0A, 16'h0B0B);
      check("handover_sel", {15'd0, sel}, 16'd1);
      check("handover_gap", {15'd0, out_valid}, 16'd0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 16'h0A0A, 16'h0B0C);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);

      // Saturated burst, then B arrives and preempts on the next edge.
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 16'(16'h5000 + i), 16'h0);
      check("sat_still_a", {15'd0, grant_a}, 16'd1);
      applyStimulus(1'b1, 1'b1, 16'h5555, 16'h6666);
      check("sat_preempt_b", {15'd0, grant_b}, 16'd1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'h0, 16'(16'h6000 + i));

      // Reset in the middle of a B burst; A wins the first contention afterwards.
      check("pre_reset_b", {15'd0, grant_b}, 16'd1);
      resetDut();
      applyStimulus(1'b1, 1'b1, 16'hC0DE, 16'hF00D);
      check("post_reset_a", {15'd0, grant_a}, 16'd1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 16'hC0DE, 16'hF00D);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       16'($urandom()), 16'($urandom()));
      end

      // Drain and confirm every predicted word was presented.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
      check("queue_drained", 16'(exp_q.size()), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
